// File: rtl/hilbert_mac_sched.sv
// Hilbert FIR with one shared multiplier: one tap per clock over a circular sample
// history, then a saturated imaginary output and the |real|+|imag| envelope.
module hilbert_mac_sched #(
  parameter int TAP_NUM    = 31,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(TAP_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         coef_we,
  input  logic [$clog2(TAP_NUM)-1:0]   coef_addr,
  input  logic signed [DATA_WIDTH-1:0] coef_wdata,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] imag_out,
  output logic [DATA_WIDTH+1:0]        env_out,
  output logic                         busy
);

  localparam int AW   = $clog2(TAP_NUM);
  localparam int HALF = (TAP_NUM - 1) / 2;
  localparam logic [AW-1:0] LAST   = AW'(TAP_NUM - 1);
  localparam logic [AW-1:0] ONE    = AW'(1);
  localparam logic [AW-1:0] HALF_A = AW'(HALF);
  localparam logic [AW-1:0] OFF_A  = AW'(TAP_NUM - HALF);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                         state_reg;
  logic [AW-1:0]                  wr_ptr_reg;
  logic [AW-1:0]                  rd_idx_reg;
  logic [AW-1:0]                  tap_reg;
  logic [AW-1:0]                  ctr_idx_reg;
  logic signed [ACC_WIDTH-1:0]    acc_reg;
  logic signed [DATA_WIDTH-1:0]   hist_reg [TAP_NUM];
  logic signed [DATA_WIDTH-1:0]   coef_reg [TAP_NUM];
  logic                           out_valid_reg;
  logic signed [DATA_WIDTH-1:0]   imag_reg;
  logic [DATA_WIDTH+1:0]          env_reg;

  logic                           handshake;
  logic                           coef_ok;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    shifted;
  logic signed [DATA_WIDTH-1:0]   imag_sat;
  logic signed [DATA_WIDTH-1:0]   real_s;
  logic signed [DATA_WIDTH:0]     real_ext;
  logic signed [DATA_WIDTH:0]     imag_ext;
  logic [DATA_WIDTH:0]            abs_real;
  logic [DATA_WIDTH:0]            abs_imag;
  logic [DATA_WIDTH+1:0]          env_next;

  assign in_ready  = !rst && (state_reg == IDLE);
  assign handshake = in_valid && in_ready;
  assign coef_ok   = !rst && (state_reg == IDLE) && coef_we && (coef_addr <= LAST);

  // Coefficient and history storage are per-entry registers so both clear on reset.
  generate
    for (genvar gi = 0; gi < TAP_NUM; gi++) begin : g_store
      always_ff @(posedge clk) begin
        if (rst) begin
          hist_reg[gi] <= '0;
        end else if (handshake && (wr_ptr_reg == AW'(gi))) begin
          hist_reg[gi] <= din;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          coef_reg[gi] <= '0;
        end else if (coef_ok && (coef_addr == AW'(gi))) begin
          coef_reg[gi] <= coef_wdata;
        end
      end
    end
  endgenerate

  assign prod    = coef_reg[tap_reg] * hist_reg[rd_idx_reg];
  assign shifted = acc_reg >>> 15;
  assign imag_sat = (shifted > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0] :
                    (shifted < SAT_MIN) ? SAT_MIN[DATA_WIDTH-1:0] :
                    shifted[DATA_WIDTH-1:0];

  // One extra bit keeps |most negative| exact.
  assign real_s   = hist_reg[ctr_idx_reg];
  assign real_ext = {real_s[DATA_WIDTH-1], real_s};
  assign imag_ext = {imag_sat[DATA_WIDTH-1], imag_sat};
  assign abs_real = real_ext[DATA_WIDTH] ? -real_ext : real_ext;
  assign abs_imag = imag_ext[DATA_WIDTH] ? -imag_ext : imag_ext;
  assign env_next = {1'b0, abs_real} + {1'b0, abs_imag};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_idx_reg    <= '0;
      tap_reg       <= '0;
      ctr_idx_reg   <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      imag_reg      <= '0;
      env_reg       <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (handshake) begin
            wr_ptr_reg  <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + ONE;
            rd_idx_reg  <= wr_ptr_reg;
            ctr_idx_reg <= (wr_ptr_reg >= HALF_A) ? wr_ptr_reg - HALF_A : wr_ptr_reg + OFF_A;
            tap_reg     <= '0;
            acc_reg     <= '0;
            state_reg   <= MAC;
          end
        end
        MAC: begin
          // Walk backwards from the newest sample, wrapping 0 -> LAST.
          acc_reg    <= acc_reg + ACC_WIDTH'(prod);
          rd_idx_reg <= (rd_idx_reg == '0) ? LAST : rd_idx_reg - ONE;
          tap_reg    <= tap_reg + ONE;
          if (tap_reg == LAST) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          imag_reg      <= imag_sat;
          env_reg       <= env_next;
          out_valid_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_reg && !rst;
  assign imag_out  = rst ? '0 : imag_reg;
  assign env_out   = rst ? '0 : env_reg;
  assign busy      = !rst && (state_reg != IDLE);

endmodule

// File: doc/hilbert_mac_sched.md
HILBERT_MAC_SCHED -- requirements
Module: hilbert_mac_sched

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter TAP_NUM, default 31, giving the number of FIR taps; it SHALL be odd and at least 3.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, giving the width of samples and coefficients.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+$clog2(TAP_NUM), giving the accumulator width.

Ports (name, direction, width, meaning):
REQ-004 clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-005 rst, input, 1, reset; it SHALL be synchronous and active-high.
REQ-006 in_valid, input, 1, a sample is offered on din.
REQ-007 in_ready, output, 1, the block accepts a sample this cycle.
REQ-008 din, input, DATA_WIDTH, signed sample.
REQ-009 coef_we, input, 1, coefficient write strobe.
REQ-010 coef_addr, input, $clog2(TAP_NUM), coefficient index.
REQ-011 coef_wdata, input, DATA_WIDTH, signed Q1.15 coefficient.
REQ-012 out_valid, output, 1, single-cycle result strobe.
REQ-013 imag_out, output, DATA_WIDTH, signed, saturated Hilbert output.
REQ-014 env_out, output, DATA_WIDTH+2, unsigned value |real|+|imag|.
REQ-015 busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 The block SHALL share one signed DATA_WIDTH x DATA_WIDTH multiplier across all taps, with one product per clock.
REQ-017 The FSM SHALL have the states IDLE, MAC and DONE, and SHALL leave reset in IDLE.
REQ-018 in_ready SHALL be 1 only in IDLE, and a handshake SHALL occur when in_valid and in_ready are both 1.
REQ-019 On a handshake at cycle T, the block SHALL write din into the sample history at the circular write pointer, advance the pointer modulo TAP_NUM, clear the accumulator, and enter MAC.
REQ-020 MAC SHALL last exactly TAP_NUM cycles, T+1 through T+TAP_NUM; on tap k = 0..TAP_NUM-1 it SHALL add the product of coef[k] and the sample k samples old (k=0 is the newest) to the accumulator.
REQ-021 The history read index SHALL wrap modulo TAP_NUM with no off-by-one at the wrap.
REQ-022 DONE SHALL occupy cycle T+TAP_NUM+1, in which the block registers its outputs.
REQ-023 out_valid SHALL be 1 for exactly one cycle, T+TAP_NUM+2, during which the FSM SHALL be in IDLE with in_ready=1.
REQ-024 The minimum handshake spacing SHALL be TAP_NUM+2 cycles.
REQ-025 The block SHALL compute imag as the accumulator arithmetically shifted right by 15, then saturated to the range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-026 The real part SHALL be the history sample (TAP_NUM-1)/2 samples old.
REQ-027 The block SHALL compute |x| in DATA_WIDTH+1 bits, so that |-32768| = 32768 exactly.
REQ-028 env_out SHALL equal |real| + |imag| with no overflow; its maximum is 65536.
REQ-029 imag_out and env_out SHALL hold their values until the next DONE.
REQ-030 A coefficient write (coef_we=1) SHALL update coef[coef_addr] only in IDLE; writes in MAC or DONE SHALL be ignored.
REQ-031 When a coefficient write and a sample handshake occur in the same IDLE cycle, the MAC pass SHALL use the new coefficient.
REQ-032 A coefficient write with coef_addr >= TAP_NUM SHALL be ignored.

Reset
REQ-033 When rst=1, the block SHALL enter IDLE, zero the history, the write pointer, the accumulator and all coefficients, and drive in_ready=0, out_valid=0, busy=0, imag_out=0 and env_out=0 in that cycle.
REQ-034 In the first cycle after rst falls, in_ready SHALL be 1.
REQ-035 Reset asserted during MAC or DONE SHALL abort the pass, and no out_valid SHALL follow.

Verification
REQ-036 Scenario: after reset, set coef[0]=0x4000, then send din=1000 -> out_valid at T+33 with imag_out=500, real=0, env_out=500.
REQ-037 Scenario: with coef all zero, send an impulse 0x7FFF followed by 15 zero samples -> the 16th result gives env_out=32767, and all other results give 0.
REQ-038 Scenario: all coef=0x7FFF and 31 samples of 0x7FFF -> imag_out=32767 (saturated), env_out=65534; with samples of 0x8000 -> imag_out=-32768, and env_out=65536 once the center tap is 0x8000.
REQ-039 Scenario: hold in_valid high for 100 cycles -> handshakes exactly 33 cycles apart, each followed by one out_valid pulse, with no lost or duplicated sample.
REQ-040 Scenario: write coef[0]=0x7FFF during MAC -> the coefficient is unchanged and the result matches the old coefficient set.
REQ-041 Scenario: assert rst at MAC cycle 10 -> no out_valid, outputs 0, and in_ready=1 on the cycle after rst falls.
